// File: rtl/ft601_pkg.sv
// ---------------------------------------------------------------------------
// ft601_pkg
// Shared definitions for the FT601 device-side bus model.
//   FT601_DATA_W      : width of the FT601 data bus
//   FT601_BE_W        : width of the FT601 byte-enable bus
//   ft601_dev_state_t : bus phase of the device model
// ---------------------------------------------------------------------------
package ft601_pkg;

  localparam int FT601_DATA_W = 32;
  localparam int FT601_BE_W   = 4;

  // IDLE     : bus released, waiting for a read request or a write strobe
  // RD_TURN  : one turnaround cycle before the device starts driving
  // RD_DRIVE : device drives data/be from the TX FIFO head
  // WR       : FPGA is writing words into the RX FIFO
  typedef enum logic [1:0] {
    DEV_IDLE     = 2'd0,
    DEV_RD_TURN  = 2'd1,
    DEV_RD_DRIVE = 2'd2,
    DEV_WR       = 2'd3
  } ft601_dev_state_t;

endpackage

// File: rtl/ft601_device_model_if.sv
// ---------------------------------------------------------------------------
// ft601_device_model_if
// FT601 245-style handshake signals shared between the FPGA controller and
// the device model. The tristate data/be bus is carried as plain inout ports
// on the device model so the bus resolution stays a simple wire.
//   usb_txe     : device -> FPGA, active low, device can accept a write
//   usb_rxf     : device -> FPGA, active low, device holds readable data
//   usb_wren_l  : FPGA -> device, write strobe, active low
//   usb_rden_l  : FPGA -> device, read strobe, active low
//   usb_outen_l : FPGA -> device, output-enable request, active low
//   usb_rst_l   : FPGA -> device, synchronous flush, active low
// Modports: master = FPGA controller side, slave = device model side.
// ---------------------------------------------------------------------------
interface ft601_device_model_if;

  logic usb_txe;
  logic usb_rxf;
  logic usb_wren_l;
  logic usb_rden_l;
  logic usb_outen_l;
  logic usb_rst_l;

  modport master (
    input  usb_txe,
    input  usb_rxf,
    output usb_wren_l,
    output usb_rden_l,
    output usb_outen_l,
    output usb_rst_l
  );

  modport slave (
    output usb_txe,
    output usb_rxf,
    input  usb_wren_l,
    input  usb_rden_l,
    input  usb_outen_l,
    input  usb_rst_l
  );

endinterface

// File: rtl/ft601_sync_fifo.sv
// ---------------------------------------------------------------------------
// ft601_sync_fifo
// Single-clock FIFO with extra-MSB pointers so full and empty are told apart
// by the pointer MSB. Also exposes the flags as they will be after the
// current edge (next_full/next_empty) so the owner can register them.
//   clk, rst   : clock, asynchronous active-high reset
//   push/wdata : write request and word
//   pop/rdata  : read request and current head word
//   flush      : synchronous clear, wins over push and pop
//   full/empty : current flags
//   next_full/next_empty : flags after the current edge
// ---------------------------------------------------------------------------
module ft601_sync_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic             next_full,
  output logic             next_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pushOk, popOk;

  // A full FIFO is never empty, so a pop on full is always real; likewise a
  // push on empty is always real. That lets a simultaneous push and pop pass
  // through either boundary with the count unchanged.
  assign pushOk = push && (!full || pop) && !flush;
  assign popOk  = pop && (!empty || push) && !flush;

  assign full  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty = (wrPtr_q == rdPtr_q);
  assign next_full  = (wrPtr_d[AW] != rdPtr_d[AW]) && (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]);
  assign next_empty = (wrPtr_d == rdPtr_d);
  assign rdata = mem_q[rdPtr_q[AW-1:0]];

  // Pointer advance; flush returns both pointers to zero.
  always_comb begin
    wrPtr_d = wrPtr_q + {{AW{1'b0}}, pushOk};
    rdPtr_d = rdPtr_q + {{AW{1'b0}}, popOk};
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem_q[wrPtr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ft601_device_model.sv
// ---------------------------------------------------------------------------
// ft601_device_model
// Device (chip) end of the FT601 245-style synchronous FIFO bus, for loopback
// benches and on-board self-test without a physical FT601.
//   clk, rst        : bus clock, asynchronous active-high reset
//   bus             : handshake signals (slave modport)
//   data, be        : tristate FT601 data/byte-enable bus
//   src_*           : host stream into the TX FIFO (read by the FPGA)
//   snk_*           : host stream out of the RX FIFO (written by the FPGA)
//   proto_err       : sticky bus-protocol violation flag
// ---------------------------------------------------------------------------
module ft601_device_model
  import ft601_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  ft601_device_model_if.slave     bus,
  inout  wire  [FT601_DATA_W-1:0] data,
  inout  wire  [FT601_BE_W-1:0]   be,
  input  logic [FT601_DATA_W-1:0] src_data,
  input  logic [FT601_BE_W-1:0]   src_be,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [FT601_DATA_W-1:0] snk_data,
  output logic [FT601_BE_W-1:0]   snk_be,
  output logic                    snk_valid,
  input  logic                    snk_ready,
  output logic                    proto_err
);

  localparam int ENTRY_W = FT601_DATA_W + FT601_BE_W;

  ft601_dev_state_t   state_q, state_d;
  logic               txe_q, rxf_q, protoErr_q;
  logic               flush, driveBus, protoViolation;
  logic               txPush, txPop, txFull, txEmpty, txNextFull, txNextEmpty;
  logic               rxPush, rxPop, rxFull, rxEmpty, rxNextFull, rxNextEmpty;
  logic [ENTRY_W-1:0] txHead, rxHead;
  logic               unusedFlags;

  assign flush  = ~bus.usb_rst_l;
  assign txPush = src_valid;
  assign txPop  = (state_q == DEV_RD_DRIVE) && ~bus.usb_rden_l && ~txEmpty;
  // Capture happens on the IDLE->WR edge as well as every WR edge, but only
  // while usb_txe is low; a write with usb_txe high is dropped.
  assign rxPush = ~bus.usb_wren_l && ~txe_q &&
                  ((state_q == DEV_WR) || ((state_q == DEV_IDLE) && bus.usb_outen_l));
  assign rxPop  = snk_ready && ~rxEmpty;

  ft601_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_txFifo (
    .clk(clk), .rst(rst),
    .push(txPush), .wdata({src_be, src_data}),
    .pop(txPop), .rdata(txHead), .flush(flush),
    .full(txFull), .empty(txEmpty),
    .next_full(txNextFull), .next_empty(txNextEmpty)
  );

  ft601_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_rxFifo (
    .clk(clk), .rst(rst),
    .push(rxPush), .wdata({be, data}),
    .pop(rxPop), .rdata(rxHead), .flush(flush),
    .full(rxFull), .empty(rxEmpty),
    .next_full(rxNextFull), .next_empty(rxNextEmpty)
  );

  assign unusedFlags = ^{txNextFull, rxFull, rxNextEmpty};

  assign protoViolation = (~bus.usb_wren_l && ~bus.usb_outen_l) ||
                          (~bus.usb_rden_l && (state_q != DEV_RD_DRIVE)) ||
                          (~bus.usb_wren_l && txe_q);

  // Bus phase sequencing; a read request has priority over a write strobe
  // in IDLE, and a flush always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEV_IDLE: begin
        if (~bus.usb_outen_l)     state_d = DEV_RD_TURN;
        else if (~bus.usb_wren_l) state_d = DEV_WR;
      end
      DEV_RD_TURN:  state_d = bus.usb_outen_l ? DEV_IDLE : DEV_RD_DRIVE;
      DEV_RD_DRIVE: if (bus.usb_outen_l) state_d = DEV_IDLE;
      DEV_WR:       if (bus.usb_wren_l)  state_d = DEV_IDLE;
      default:      state_d = DEV_IDLE;
    endcase
    if (flush) state_d = DEV_IDLE;
  end

  // Status flags are registered from the FIFOs' next-state flags so they
  // change on the same edge as the push/pop that causes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DEV_IDLE;
      txe_q      <= 1'b1;
      rxf_q      <= 1'b1;
      protoErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txe_q      <= rxNextFull;
      rxf_q      <= txNextEmpty;
      protoErr_q <= protoErr_q | protoViolation;
    end
  end

  // Drive only in RD_DRIVE; since state_q resets asynchronously, an rst
  // mid-burst releases the bus without waiting for a clock.
  assign driveBus = (state_q == DEV_RD_DRIVE);
  assign data = driveBus ? txHead[FT601_DATA_W-1:0] : 'z;
  assign be   = driveBus ? (txEmpty ? '0 : txHead[ENTRY_W-1:FT601_DATA_W]) : 'z;

  assign bus.usb_txe = txe_q;
  assign bus.usb_rxf = rxf_q;
  assign src_ready   = ~txFull;
  assign snk_data    = rxHead[FT601_DATA_W-1:0];
  assign snk_be      = rxHead[ENTRY_W-1:FT601_DATA_W];
  assign snk_valid   = ~rxEmpty;
  assign proto_err   = protoErr_q;

endmodule

// File: tb/tb_ft601_device_model.sv
// ---------------------------------------------------------------------------
// tb_ft601_device_model
// Self-checking bench for ft601_device_model. The bench plays the FPGA
// controller and the host streams; a queue-based model predicts every
// output each cycle, and directed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_ft601_device_model;

  localparam int DEPTH = 16;
  localparam int MODE_IDLE  = 0;
  localparam int MODE_TURN  = 1;
  localparam int MODE_DRIVE = 2;
  localparam int MODE_WR    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ft601_device_model_if busIf ();

  // Pull-ups make a released bus read as all ones in a two-state simulator.
  tri1 [31:0] data;
  tri1 [3:0]  be;
  logic        tbDrive = 1'b0;
  logic [31:0] tbData  = '0;
  logic [3:0]  tbBe    = '0;
  assign data = tbDrive ? tbData : 'z;
  assign be   = tbDrive ? tbBe   : 'z;

  logic [31:0] srcData = '0;
  logic [3:0]  srcBe   = 4'hF;
  logic        srcValid = 1'b0;
  logic        srcReady;
  logic [31:0] snkData;
  logic [3:0]  snkBe;
  logic        snkValid;
  logic        snkReady = 1'b0;
  logic        protoErr;

  int checks   = 0;
  int failures = 0;

  ft601_device_model #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(busIf.slave),
    .data(data), .be(be),
    .src_data(srcData), .src_be(srcBe), .src_valid(srcValid), .src_ready(srcReady),
    .snk_data(snkData), .snk_be(snkBe), .snk_valid(snkValid), .snk_ready(snkReady),
    .proto_err(protoErr)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic wrL, input logic rdL, input logic oeL, input logic rstL);
    busIf.usb_wren_l  = wrL;
    busIf.usb_rden_l  = rdL;
    busIf.usb_outen_l = oeL;
    busIf.usb_rst_l   = rstL;
  endtask

  // Reference model: FIFO contents as queues plus the bus phase.
  logic [35:0] txQ[$];
  logic [35:0] rxQ[$];
  int   mode;
  logic expTxe, expRxf, expErr;

  initial begin
    mode = MODE_IDLE; expTxe = 1'b1; expRxf = 1'b1; expErr = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    logic wrL, rdL, oeL, popTx, pushTx, capture, popRx;
    if (rst) begin
      txQ.delete(); rxQ.delete();
      mode = MODE_IDLE; expTxe = 1'b1; expRxf = 1'b1; expErr = 1'b0;
    end else begin
      wrL = busIf.usb_wren_l; rdL = busIf.usb_rden_l; oeL = busIf.usb_outen_l;
      popTx   = (mode == MODE_DRIVE) && !rdL && (txQ.size() > 0);
      pushTx  = srcValid && ((txQ.size() < DEPTH) || popTx);
      capture = !wrL && !expTxe && ((mode == MODE_WR) || ((mode == MODE_IDLE) && oeL));
      popRx   = snkReady && (rxQ.size() > 0);
      if ((!wrL && !oeL) || (!rdL && mode != MODE_DRIVE) || (!wrL && expTxe)) expErr = 1'b1;
      if (!busIf.usb_rst_l) begin
        txQ.delete(); rxQ.delete();
        mode = MODE_IDLE;
      end else begin
        if (popTx)   void'(txQ.pop_front());
        if (pushTx)  txQ.push_back({srcBe, srcData});
        if (popRx)   void'(rxQ.pop_front());
        if (capture) rxQ.push_back({tbBe, tbData});
        if (mode == MODE_IDLE)       mode = !oeL ? MODE_TURN : (!wrL ? MODE_WR : MODE_IDLE);
        else if (mode == MODE_TURN)  mode = !oeL ? MODE_DRIVE : MODE_IDLE;
        else if (mode == MODE_DRIVE) mode = oeL ? MODE_IDLE : MODE_DRIVE;
        else                         mode = wrL ? MODE_IDLE : MODE_WR;
      end
      expTxe = (rxQ.size() == DEPTH);
      expRxf = (txQ.size() == 0);
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    checkOutput("usb_txe", busIf.usb_txe, expTxe);
    checkOutput("usb_rxf", busIf.usb_rxf, expRxf);
    checkOutput("proto_err", protoErr, expErr);
    checkOutput("src_ready", srcReady, txQ.size() < DEPTH);
    checkOutput("snk_valid", snkValid, rxQ.size() > 0);
    if (rxQ.size() > 0) begin
      checkOutput("snk_data", snkData, rxQ[0][31:0]);
      checkOutput("snk_be", snkBe, rxQ[0][35:32]);
    end
    if (!tbDrive) begin
      if (mode == MODE_DRIVE) begin
        if (txQ.size() > 0) begin
          checkOutput("bus_data", data, txQ[0][31:0]);
          checkOutput("bus_be", be, txQ[0][35:32]);
        end else begin
          checkOutput("bus_be_empty", be, 4'h0);
        end
      end else begin
        checkOutput("bus_data_z", data, 32'hFFFF_FFFF);
        checkOutput("bus_be_z", be, 4'hF);
      end
    end
  end

  initial begin
    int drained;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Reset held for five cycles.
    repeat (5) tick();
    checkOutput("reset_txe", busIf.usb_txe, 1'b1);
    checkOutput("reset_rxf", busIf.usb_rxf, 1'b1);
    checkOutput("reset_bus_z", data, 32'hFFFF_FFFF);
    checkOutput("reset_snk_valid", snkValid, 1'b0);
    checkOutput("reset_proto_err", protoErr, 1'b0);
    checkOutput("reset_src_ready", srcReady, 1'b1);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_txe", busIf.usb_txe, 1'b0);

    // Read of three host words.
    checkOutput("read_rxf_before", busIf.usb_rxf, 1'b1);
    srcValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      srcData = 32'hF000_0000 + i;
      tick();
      if (i == 1) checkOutput("read_rxf_after_push", busIf.usb_rxf, 1'b0);
    end
    srcValid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("read_turn_bus_z", data, 32'hFFFF_FFFF);
    tick();
    checkOutput("read_word1", data, 32'hF000_0001);
    checkOutput("read_be1", be, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checkOutput("read_word2", data, 32'hF000_0002);
    tick();
    checkOutput("read_word3", data, 32'hF000_0003);
    tick();
    checkOutput("read_rxf_last_pop", busIf.usb_rxf, 1'b1);
    checkOutput("read_be_empty", be, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkOutput("read_release", data, 32'hFFFF_FFFF);
    checkOutput("read_proto_err", protoErr, 1'b0);

    // Write DEPTH+1 words; the last one overflows.
    tbDrive = 1'b1;
    tbBe = 4'hF;
    for (int i = 0; i <= DEPTH; i++) begin
      tbData = 32'hA000_0000 + i;
      busIf.usb_wren_l = 1'b0;
      tick();
      if (i == DEPTH - 2) checkOutput("full_txe_before", busIf.usb_txe, 1'b0);
      if (i == DEPTH - 1) checkOutput("full_txe_at_fill", busIf.usb_txe, 1'b1);
    end
    checkOutput("full_overflow_err", protoErr, 1'b1);
    busIf.usb_wren_l = 1'b1;
    tbDrive = 1'b0;
    tick();
    snkReady = 1'b1;
    drained = 0;
    for (int c = 0; c < 2 * DEPTH && snkValid; c++) begin
      checkOutput("drain_word", snkData, 32'hA000_0000 + drained);
      drained++;
      tick();
    end
    checkOutput("drain_count", drained, DEPTH);
    snkReady = 1'b0;
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Streaming writes with the sink always ready.
    snkReady = 1'b1;
    tbDrive = 1'b1;
    tbBe = 4'h0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      tbData = 32'hB000_0000 + i;
      busIf.usb_wren_l = 1'b0;
      tick();
      checkOutput("wrap_txe", busIf.usb_txe, 1'b0);
      checkOutput("wrap_head", snkData, 32'hB000_0000 + i);
      checkOutput("wrap_be", snkBe, 4'h0);
    end
    busIf.usb_wren_l = 1'b1;
    tbDrive = 1'b0;
    tick();
    checkOutput("wrap_drained", snkValid, 1'b0);
    snkReady = 1'b0;

    // Write strobe together with output enable.
    checkOutput("pre_contention_err", protoErr, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    checkOutput("contention_err", protoErr, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    checkOutput("contention_sticky", protoErr, 1'b1);

    // Flush with four words in each FIFO and a host push on the same edge.
    srcValid = 1'b1;
    tbBe = 4'hF;
    for (int i = 0; i < 4; i++) begin
      srcData = 32'hC000_0000 + i;
      tick();
    end
    srcValid = 1'b0;
    tbDrive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tbData = 32'hD000_0000 + i;
      busIf.usb_wren_l = 1'b0;
      tick();
    end
    busIf.usb_wren_l = 1'b1;
    tbDrive = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("flush_pre_drive", data, 32'hC000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    srcValid = 1'b1;
    srcData = 32'hDEAD_BEEF;
    tick();
    checkOutput("flush_rxf", busIf.usb_rxf, 1'b1);
    checkOutput("flush_txe", busIf.usb_txe, 1'b0);
    checkOutput("flush_snk_valid", snkValid, 1'b0);
    checkOutput("flush_bus_z", data, 32'hFFFF_FFFF);
    checkOutput("flush_keeps_err", protoErr, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    srcValid = 1'b0;
    tick();
    checkOutput("flush_push_dropped", busIf.usb_rxf, 1'b1);

    // Asynchronous reset in the middle of a read releases the bus at once.
    srcValid = 1'b1;
    srcData = 32'hE000_0001;
    tick();
    srcValid = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (2) tick();
    checkOutput("async_pre_drive", data, 32'hE000_0001);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_release_data", data, 32'hFFFF_FFFF);
    checkOutput("async_release_be", be, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("async_err_cleared", protoErr, 1'b0);
    checkOutput("async_rxf", busIf.usb_rxf, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft601_device_model.md
# ft601_device_model

Synthesizable model of the FT601 chip side of the 245-style synchronous FIFO bus, i.e. the device end that `ft601_controller` talks to. It presents `usb_txe`/`usb_rxf`, drives the tristate `data`/`be` bus on reads, and captures words on writes. A host-side stream interface supplies words that the FPGA reads, and drains words that the FPGA writes. It is used for loopback benches and for on-board self-test without a physical FT601.

## Interface
Parameters:
- `DEPTH`, 16: words per internal FIFO. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1: bus clock (the FT601 CLK domain).
- `rst`  in  1: asynchronous, active-high reset.
- `usb_txe`  out  1: active low; 0 = model can accept an FPGA write.
- `usb_rxf`  out  1: active low; 0 = model holds data for the FPGA to read.
- `usb_wren_l`  in  1: FPGA write strobe, active low.
- `usb_rden_l`  in  1: FPGA read strobe, active low.
- `usb_outen_l`  in  1: FPGA output-enable request, active low.
- `usb_rst_l`  in  1: synchronous flush, active low.
- `data`  inout  32: FT601 data bus.
- `be`  inout  4: FT601 byte enables.
- `src_data`  in  32: host word to be read by the FPGA.
- `src_be`  in  4: byte enables for `src_data`.
- `src_valid`  in  1: host push request.
- `src_ready`  out  1: push accepted; equals "TX FIFO not full".
- `snk_data`  out  32: oldest word the FPGA has written.
- `snk_be`  out  4: byte enables for `snk_data`.
- `snk_valid`  out  1: equals "RX FIFO not empty".
- `snk_ready`  in  1: host pop.
- `proto_err`  out  1: sticky bus-protocol violation flag.

## Operation
- **Two FIFOs.**
  - TX FIFO: host → FPGA, 36-bit entries.
  - RX FIFO: FPGA → host, 36-bit entries.
  - Each uses `$clog2(DEPTH)+1`-bit pointers. Wrap is at `DEPTH`; full and empty are distinguished by the MSB.
- **FSM states:** IDLE, RD_TURN, RD_DRIVE, WR.
- **IDLE:**
  - `usb_outen_l`=0 → RD_TURN.
  - Else `usb_wren_l`=0 → WR, and the word is captured on this edge if `usb_txe`=0.
- **RD_TURN:** one turnaround cycle with the bus still released. Next state is RD_DRIVE if `usb_outen_l`=0, otherwise IDLE.
- **RD_DRIVE:**
  - `data`/`be` drive the TX FIFO head. If the FIFO is empty, the bus drives `be`=4'b0000.
  - A pop happens on each edge where `usb_rden_l`=0 and the FIFO is not empty.
  - `usb_outen_l`=1 → IDLE, and the bus is released from that edge.
- **WR:**
  - Captures `data`/`be` on each edge where `usb_wren_l`=0 and `usb_txe`=0.
  - `usb_wren_l`=1 → IDLE.
- **Bus drive:** the bus is driven only while state == RD_DRIVE. It is high-Z otherwise.
- **`proto_err`** sets on any of the following and clears only on `rst`:
  - `usb_wren_l`=0 and `usb_outen_l`=0 in the same cycle.
  - `usb_rden_l`=0 outside RD_DRIVE.
  - `usb_wren_l`=0 while `usb_txe`=1; the word is dropped.
- **Flush:** `usb_rst_l`=0 empties both FIFOs, forces IDLE and releases the bus at the next edge. `proto_err` is unaffected.
- **Byte enables:** words with `be`=0000 are still captured and delivered unchanged.

## Timing
- **Reset values:**
  - `usb_txe`=1, `usb_rxf`=1.
  - `data`/`be` high-Z.
  - `snk_valid`=0, `src_ready`=1 (after reset), `proto_err`=0.
  - FSM in IDLE.
- **Mid-operation reset:** `rst` asserted mid-burst releases the bus immediately, without waiting for a clock.
- **`usb_rxf` and `usb_txe`:** both are registered. `usb_rxf` is next-state(TX empty); `usb_txe` is next-state(RX full).
  - Host push into an empty TX FIFO → `usb_rxf`=0 one cycle later.
  - Popping the last word → `usb_rxf`=1 at that same edge.
  - The write that fills the RX FIFO → `usb_txe`=1 at that same edge.
- **Read latency:**
  - `usb_outen_l` sampled low at edge N.
  - The bus is driven after edge N+1.
  - The first pop can occur at edge N+2.
- **Simultaneous push and pop:** a push and a pop on the same FIFO in the same cycle leave the count unchanged. This holds when the FIFO is full, as long as the pop is real. It also holds when the FIFO is empty, but only if the push is real.
- **Flush vs. push:** a flush in the same cycle as a host push wins; the push is discarded.

## Structure
- **`ft601_pkg`:**
  - `ft601_dev_state_t` enum.
  - `FT601_DATA_W`=32, `FT601_BE_W`=4.
- **Sub-module `ft601_sync_fifo`:**
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, flush, full, empty, next_full, next_empty.
  - Instantiated twice.
- **Top level:** holds the FSM, the tristate drivers and the error logic.

## Test plan
- **Reset:** hold `rst` 5 cycles → `usb_txe`=`usb_rxf`=1, bus Z, `snk_valid`=0, `proto_err`=0.
- **Read:** push F0000001, F0000002, F0000003 (`be` 1111) → `usb_rxf`=0 one cycle after the first push. Then `outen_l`=0, and `rden_l`=0 from N+2 for 3 cycles → bus shows the three words in order, and `usb_rxf`=1 at the last pop edge.
- **Write to full:** write `DEPTH`+1 words A0000000+i while `usb_txe` is low → `usb_txe`=1 at the `DEPTH`th edge. The extra write sets `proto_err`, and the sink drains exactly `DEPTH` words in order.
- **Wrap-around:** with `snk_ready`=1 continuously, stream 3×`DEPTH` writes → no loss, count never exceeds 1, `usb_txe` stays 0.
- **Contention:** `usb_wren_l`=0 with `usb_outen_l`=0 → `proto_err`=1 next cycle, and it persists until `rst`.
- **Flush:** `usb_rst_l`=0 for 1 cycle with 4 words in each FIFO → both empty, `usb_rxf`=1, `usb_txe`=0, bus Z.
